// File: rtl/mmm_arbiter_rr.sv
// Round-robin owner/sequencer for one shared Montgomery multiplier.
// Optional MMM_ARB_LOCK_EN adds a lock input for back-to-back operations.
module mmm_arbiter_rr #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
`ifdef MMM_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [SW-1:0]   sel,
  output logic            rst_mmm,
  output logic            ld_a,
  output logic            ld_r,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    RUN,
    POST
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   owner;
  logic [SW-1:0]   last;
  logic [SW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] onehot;
  logic            keep;

  // Search starts just after the previous winner.
  always_comb begin
    logic [NREQ-1:0] sh;
    int idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
  end

`ifdef MMM_ARB_LOCK_EN
  assign keep = lock[owner] & req[owner];
`else
  assign keep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= '0;
      last  <= SW'(NREQ - 1);
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            state <= PRE;
          end
        end
        PRE: begin
          cnt   <= '0;
          state <= req[owner] ? RUN : IDLE;
        end
        RUN: begin
          if (!req[owner]) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CMAX) begin
            state <= POST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        POST: begin
          cnt <= '0;
          if (keep) begin
            state <= PRE;
          end else begin
            last  <= owner;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign onehot  = NREQ'(1) << owner;
  assign busy    = (state != IDLE);
  assign rst_mmm = busy;
  assign ld_a    = (state == PRE);
  assign ld_r    = (state == POST);
  assign gnt     = busy ? onehot : '0;
  assign done    = ld_r ? onehot : '0;
  assign sel     = owner;

endmodule

// File: tb/tb_mmm_arbiter_rr.sv
// Bench for mmm_arbiter_rr: vector table, corner sequences, random vs model.
module tb_mmm_arbiter_rr;

  localparam int W    = 8;
  localparam int NREQ = 2;
  localparam int SW   = 1;

  logic            clk = 1'b0;
  logic            rstb;
  logic            ena;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [SW-1:0]   sel;
  logic            rst_mmm;
  logic            ld_a;
  logic            ld_r;
  logic [NREQ-1:0] done;
  logic            busy;
`ifdef MMM_ARB_LOCK_EN
  logic [NREQ-1:0] lock = '0;
`endif

  always #5 clk = ~clk;

  mmm_arbiter_rr #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (ena),
    .req    (req),
`ifdef MMM_ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .sel    (sel),
    .rst_mmm(rst_mmm),
    .ld_a   (ld_a),
    .ld_r   (ld_r),
    .done   (done),
    .busy   (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: owner index (-1 = free) and cycles elapsed since grant.
  int m_own, m_age, m_last, m_sel;

  task automatic model_reset();
    m_own = -1; m_age = 0; m_last = NREQ - 1; m_sel = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    if (m_own < 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int j;
        j = (m_last + i) % NREQ;
        if (m_own < 0 && r[j]) begin
          m_own = j; m_age = 0; m_sel = j;
        end
      end
    end else if (m_age <= W + 1 && !r[m_own]) begin
      m_own = -1;
    end else if (m_age == W + 2) begin
      m_last = m_own; m_own = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic model_cmp();
    logic [NREQ-1:0] eg;
    logic act, post;
    act  = (m_own >= 0);
    post = act && m_age == W + 2;
    eg   = act ? (NREQ'(1) << m_own) : '0;
    check("m_gnt", 32'(gnt), 32'(eg));
    check("m_sel", 32'(sel), 32'(m_sel));
    check("m_busy", 32'(busy), 32'(act));
    check("m_rst_mmm", 32'(rst_mmm), 32'(act));
    check("m_ld_a", 32'(ld_a), 32'(act && m_age == 0));
    check("m_ld_r", 32'(ld_r), 32'(post));
    check("m_done", 32'(done), 32'(post ? eg : '0));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstb && ena) model_step(req);
    @(negedge clk);
    model_cmp();
  endtask

  task automatic do_reset();
    rstb = 1'b0; req = '0; ena = 1'b1;
    #1;
    model_reset();
    model_cmp();
    @(negedge clk);
    rstb = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   sel;
    logic [3:0]      strb;  // rst_mmm, ld_a, ld_r, busy
    logic [NREQ-1:0] done;
  } vec_t;

  vec_t tv[13];

  initial begin
    int dn0, dn1, ng10, ng01, ndone, nrun, g_frz;
    tv[0] = '{2'b01, 2'b01, 1'b0, 4'b1101, 2'b00};
    for (int k = 1; k <= 9; k++)
      tv[k] = '{2'b01, 2'b01, 1'b0, 4'b1001, 2'b00};
    tv[10] = '{2'b01, 2'b01, 1'b0, 4'b1011, 2'b01};
    tv[11] = '{2'b00, 2'b00, 1'b0, 4'b0000, 2'b00};
    tv[12] = '{2'b00, 2'b00, 1'b0, 4'b0000, 2'b00};

    rstb = 1'b0; ena = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_strb", 32'({rst_mmm, ld_a, ld_r, busy, sel}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rstb = 1'b1;

    // single requester, cycle by cycle
    for (int k = 0; k < 13; k++) begin
      req = tv[k].req;
      tick();
      check($sformatf("tv%0d_gnt", k), 32'(gnt), 32'(tv[k].gnt));
      check($sformatf("tv%0d_sel", k), 32'(sel), 32'(tv[k].sel));
      check($sformatf("tv%0d_strb", k),
            32'({rst_mmm, ld_a, ld_r, busy}), 32'(tv[k].strb));
      check($sformatf("tv%0d_done", k), 32'(done), 32'(tv[k].done));
    end

    // simultaneous requests alternate
    do_reset();
    req = 2'b11;
    dn0 = 0; dn1 = 0; ng10 = 0; ng01 = 0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (done == 2'b01 && dn0 == 0) dn0 = n;
      if (done == 2'b10 && dn1 == 0) dn1 = n;
      if (n == 1) check("sim_first", 32'(gnt), 32'b01);
      if (n == 13) ng10 = int'(gnt);
      if (n == 25) ng01 = int'(gnt);
    end
    check("sim_done0_at", 32'(dn0), 32'd11);
    check("sim_done1_at", 32'(dn1), 32'd23);
    check("sim_gnt10", 32'(ng10), 32'b10);
    check("sim_gnt01", 32'(ng01), 32'b01);

    // abort: no done, pointer unchanged
    do_reset();
    req = 2'b01;
    repeat (5) tick();
    req = 2'b00;
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done != 0) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);
    req = 2'b11;
    tick();
    check("abort_regnt", 32'(gnt), 32'b01);
    req = 2'b00;
    repeat (3) tick();

    // freeze: done slips by exactly the frozen cycles
    do_reset();
    req = 2'b01;
    dn0 = 0; g_frz = 1;
    for (int n = 1; n <= 20; n++) begin
      ena = (n >= 6 && n <= 8) ? 1'b0 : 1'b1;
      tick();
      if (n >= 6 && n <= 8 && !(gnt == 2'b01 && rst_mmm && !ld_r)) g_frz = 0;
      if (done == 2'b01 && dn0 == 0) dn0 = n;
      if (done != 0) req = 2'b00;
    end
    ena = 1'b1;
    check("frz_hold", 32'(g_frz), 32'd1);
    check("frz_done_at", 32'(dn0), 32'd14);

    // async reset mid-RUN, then requester 1 gets a full run
    do_reset();
    req = 2'b01;
    repeat (5) tick();
    rstb = 1'b0;
    #1;
    model_reset();
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_flags", 32'({rst_mmm, busy, done}), 32'd0);
    @(negedge clk);
    rstb = 1'b1; req = 2'b10;
    dn1 = 0; nrun = 0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (rst_mmm && !ld_a && !ld_r) nrun++;
      if (done == 2'b10 && dn1 == 0) begin
        dn1 = n; req = 2'b00;
      end
    end
    check("arst_done_at", 32'(dn1), 32'd11);
    check("arst_run_len", 32'(nrun), 32'(W + 1));

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (done[i] ? ($urandom_range(99) < 60) : ($urandom_range(99) < 2))
            req[i] = 1'b0;
        end else if ($urandom_range(99) < 30) begin
          req[i] = 1'b1;
        end
      end
      ena  = ($urandom_range(99) < 90);
      rstb = ($urandom_range(199) != 0);
      if (!rstb) begin
        #1;
        model_reset();
        model_cmp();
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
